ctrl_pipeline: RTL and testbench
================================

// Module: ctrl_pipeline
// PURPOSE
//   Downstream of the decode control unit: carries its per-instruction control bundle
//   and destination register through the EX, MEM and WB pipeline registers.
//   Detects load-use hazards, requests a stall and inserts a bubble into EX.
//   Applies branch/jump flushes and counts stall and flush cycles for performance debug.
// PARAMETERS
//   REG_ADDR_W  5   register-file address width
//   CNT_W       16  width of the saturating stall/flush counters
// PORTS
//   clk           in   1           system clock, rising-edge
//   arst_n        in   1           asynchronous active-low reset
//   id_valid      in   1           ID stage holds a real instruction
//   id_alu_op     in   2           decoded ALU op class
//   id_reg_dst    in   1           1: dest=rd, 0: dest=rt
//   id_alu_src    in   1           1: ALU operand B = immediate
//   id_branch     in   1           beq
//   id_mem_read   in   1           load
//   id_mem_write  in   1           store
//   id_mem_2_reg  in   1           1: WB data from memory
//   id_reg_write  in   1           writes register file
//   id_jump       in   1           jump
//   id_rs,id_rt,id_rd in REG_ADDR_W instruction register fields
//   flush         in   1           branch/jump taken; squash younger instrs in EX and MEM
//   stall         out  1           combinational; hold PC and IF/ID this cycle
//   ex_valid,ex_alu_op,ex_alu_src,ex_rt            out  1/2/1/REG_ADDR_W
//   ex_write_reg  out  REG_ADDR_W  resolved destination (rd or rt)
//   mem_valid,mem_branch,mem_jump,mem_mem_read,mem_mem_write  out 1 each
//   mem_write_reg out  REG_ADDR_W
//   wb_valid,wb_reg_write,wb_mem_2_reg  out 1 each
//   wb_write_reg  out  REG_ADDR_W
//   stall_cnt,flush_cnt out CNT_W  saturating event counters
// BEHAVIOUR
// - Reset (arst_n=0, async, immediate): every output and internal register 0; counters 0.
// - Normal advance each rising edge: ID->EX, EX->MEM, MEM->WB; 1 cycle/stage, WB 3 cycles after ID.
// - EX entry: ex_write_reg = id_reg_dst ? id_rd : id_rt. Sanitize before latching:
//   if !id_valid or id_jump: reg_write, mem_read, mem_write, branch stored 0 (X-free).
//   If resolved dest==0: reg_write stored 0. Other fields latched unchanged.
// - Bubble = valid 0, all control bits 0, write_reg 0.
// - Hazard (comb) = id_valid & ex_valid & ex_mem_read & ex_rt!=0 & (ex_rt==id_rs | ex_rt==id_rt).
// - stall = hazard & ~flush. On stall: EX loads bubble; MEM and WB advance normally.
//   Upstream holds ID; hazard clears next cycle as the load leaves EX (exactly 1 stall cycle).
// - flush at edge: EX and MEM load bubbles; WB takes old MEM content (the branch/jump itself).
//   flush has priority over stall; simultaneous -> no stall, flush_cnt increments.
// - Stall/flush never modify WB contents; an instruction in MEM always reaches WB.
// - stall_cnt +1 per cycle stall=1; flush_cnt +1 per cycle flush=1; both saturate at all-ones.
// - Back-to-back flushes each squash; flush during stall squashes the bubble (harmless).
// TESTING
// 1 Reset: arst_n low mid-stream between edges -> all outputs 0 immediately; stay 0 until release.
// 2 add r3,r1,r2 (reg_dst=1,reg_write=1,rd=3) -> ex@+1, mem@+2, wb_reg_write=1, wb_write_reg=3 @+3.
// 3 lw r5 then add r6,r5,r1 next -> stall=1 one cycle, ex_valid=0 bubble, add in EX one cycle later; stall_cnt=1.
// 4 beq in MEM with flush=1, lw-use hazard same cycle -> stall=0, ex/mem_valid=0 next, wb_valid=1, flush_cnt=1.
// 5 jump with id_reg_write=X -> ex/mem/wb write enables 0, mem_jump=1; addi dest r0 -> wb_reg_write=0.
// 6 CNT_W=2, 5 stall cycles -> stall_cnt sticks at 3.

Source files
------------

// File: rtl/ctrl_pipeline.sv
// Control pipeline: carries decoded control bits and destination register ID->EX->MEM->WB.
// Latency: one cycle per stage, so an instruction reaches WB three edges after it sits in ID.
// Backpressure: a combinational load-use stall inserts one EX bubble, and flush squashes EX and MEM.
//
// Ports:
//   clk, arst_n                     clock and asynchronous active-low reset
//   id_*                            decoded control bundle and register fields of the instruction in ID
//   flush                           taken branch/jump, which squashes the younger instructions in EX and MEM
//   stall                           hold PC and IF/ID this cycle (combinational)
//   ex_*, mem_*, wb_*               pipeline register contents visible downstream
//   stall_cnt, flush_cnt            saturating event counters for performance debug
module ctrl_pipeline #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  id_valid,
    input  logic [1:0]            id_alu_op,
    input  logic                  id_reg_dst,
    input  logic                  id_alu_src,
    input  logic                  id_branch,
    input  logic                  id_mem_read,
    input  logic                  id_mem_write,
    input  logic                  id_mem_2_reg,
    input  logic                  id_reg_write,
    input  logic                  id_jump,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  flush,
    output logic                  stall,
    output logic                  ex_valid,
    output logic [1:0]            ex_alu_op,
    output logic                  ex_alu_src,
    output logic [REG_ADDR_W-1:0] ex_rt,
    output logic [REG_ADDR_W-1:0] ex_write_reg,
    output logic                  mem_valid,
    output logic                  mem_branch,
    output logic                  mem_jump,
    output logic                  mem_mem_read,
    output logic                  mem_mem_write,
    output logic [REG_ADDR_W-1:0] mem_write_reg,
    output logic                  wb_valid,
    output logic                  wb_reg_write,
    output logic                  wb_mem_2_reg,
    output logic [REG_ADDR_W-1:0] wb_write_reg,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    // EX-stage state that is not exported but must travel on to MEM/WB
    logic ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump, ex_mem_2_reg;
    // MEM-stage state that is not exported but must travel on to WB
    logic mem_reg_write, mem_mem_2_reg;

    logic                  hazard;
    logic                  id_kill;
    logic [REG_ADDR_W-1:0] id_dest;
    logic                  id_reg_write_s, id_mem_read_s, id_mem_write_s, id_branch_s;

    // A load in EX whose target feeds the instruction in ID. Loads to r0 never hazard.
    assign hazard = id_valid & ex_valid & ex_mem_read & (ex_rt != '0) &
                    ((ex_rt == id_rs) | (ex_rt == id_rt));
    // A flush squashes the dependent instruction anyway, so there is no reason to hold it.
    assign stall  = hazard & ~flush;

    // Sanitize side-effecting enables so that a non-instruction or a jump (whose decode may
    // leave them undefined) can never write state further down the pipe.
    always_comb begin
        id_kill        = ~id_valid | id_jump;
        id_dest        = id_reg_dst ? id_rd : id_rt;
        id_reg_write_s = 1'b0;
        id_mem_read_s  = 1'b0;
        id_mem_write_s = 1'b0;
        id_branch_s    = 1'b0;
        if (!id_kill) begin
            id_reg_write_s = id_reg_write & (id_dest != '0);
            id_mem_read_s  = id_mem_read;
            id_mem_write_s = id_mem_write;
            id_branch_s    = id_branch;
        end
    end

    // ID -> EX: a bubble is loaded on flush or on stall
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n || 1'b0) begin
            ex_valid     <= 1'b0;
            ex_alu_op    <= '0;
            ex_alu_src   <= 1'b0;
            ex_rt        <= '0;
            ex_write_reg <= '0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
            ex_branch    <= 1'b0;
            ex_jump      <= 1'b0;
            ex_mem_2_reg <= 1'b0;
        end else if (flush || stall) begin
            ex_valid     <= 1'b0;
            ex_alu_op    <= '0;
            ex_alu_src   <= 1'b0;
            ex_rt        <= '0;
            ex_write_reg <= '0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
            ex_branch    <= 1'b0;
            ex_jump      <= 1'b0;
            ex_mem_2_reg <= 1'b0;
        end else begin
            ex_valid     <= id_valid;
            ex_alu_op    <= id_alu_op;
            ex_alu_src   <= id_alu_src;
            ex_rt        <= id_rt;
            ex_write_reg <= id_dest;
            ex_reg_write <= id_reg_write_s;
            ex_mem_read  <= id_mem_read_s;
            ex_mem_write <= id_mem_write_s;
            ex_branch    <= id_branch_s;
            ex_jump      <= id_jump;
            ex_mem_2_reg <= id_mem_2_reg;
        end
    end

    // EX -> MEM: a stall does not affect this stage, since its bubble has already been placed in EX
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            mem_valid     <= 1'b0;
            mem_branch    <= 1'b0;
            mem_jump      <= 1'b0;
            mem_mem_read  <= 1'b0;
            mem_mem_write <= 1'b0;
            mem_write_reg <= '0;
            mem_reg_write <= 1'b0;
            mem_mem_2_reg <= 1'b0;
        end else if (flush) begin
            mem_valid     <= 1'b0;
            mem_branch    <= 1'b0;
            mem_jump      <= 1'b0;
            mem_mem_read  <= 1'b0;
            mem_mem_write <= 1'b0;
            mem_write_reg <= '0;
            mem_reg_write <= 1'b0;
            mem_mem_2_reg <= 1'b0;
        end else begin
            mem_valid     <= ex_valid;
            mem_branch    <= ex_branch;
            mem_jump      <= ex_jump;
            mem_mem_read  <= ex_mem_read;
            mem_mem_write <= ex_mem_write;
            mem_write_reg <= ex_write_reg;
            mem_reg_write <= ex_reg_write;
            mem_mem_2_reg <= ex_mem_2_reg;
        end
    end

    // MEM -> WB: unconditional, because the resolving branch/jump in MEM must still retire
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            wb_mem_2_reg <= 1'b0;
            wb_write_reg <= '0;
        end else begin
            wb_valid     <= mem_valid;
            wb_reg_write <= mem_reg_write;
            wb_mem_2_reg <= mem_mem_2_reg;
            wb_write_reg <= mem_write_reg;
        end
    end

    // Saturating event counters
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
            if (flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Directed testbench for ctrl_pipeline, with hand-computed expectations.
// A second instance with 2-bit counters shares the same stimulus and is used to check saturation.
// The bench has no backpressure of its own: it drives ID as a stalled upstream would.
module tb_ctrl_pipeline;

    logic       clk = 1'b0;
    logic       arst_n = 1'b0;
    logic       id_valid, id_reg_dst, id_alu_src, id_branch, id_mem_read, id_mem_write;
    logic       id_mem_2_reg, id_reg_write, id_jump, flush;
    logic [1:0] id_alu_op;
    logic [4:0] id_rs, id_rt, id_rd;

    logic        stall, ex_valid, ex_alu_src, mem_valid, mem_branch, mem_jump;
    logic        mem_mem_read, mem_mem_write, wb_valid, wb_reg_write, wb_mem_2_reg;
    logic [1:0]  ex_alu_op;
    logic [4:0]  ex_rt, ex_write_reg, mem_write_reg, wb_write_reg;
    logic [15:0] stall_cnt, flush_cnt;

    logic        d2_stall, d2_ex_valid, d2_ex_alu_src, d2_mem_valid, d2_mem_branch, d2_mem_jump;
    logic        d2_mem_mem_read, d2_mem_mem_write, d2_wb_valid, d2_wb_reg_write, d2_wb_mem_2_reg;
    logic [1:0]  d2_ex_alu_op;
    logic [4:0]  d2_ex_rt, d2_ex_write_reg, d2_mem_write_reg, d2_wb_write_reg;
    logic [1:0]  d2_stall_cnt, d2_flush_cnt;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    ctrl_pipeline #(.REG_ADDR_W(5), .CNT_W(16)) dut (
        .clk(clk), .arst_n(arst_n),
        .id_valid(id_valid), .id_alu_op(id_alu_op), .id_reg_dst(id_reg_dst),
        .id_alu_src(id_alu_src), .id_branch(id_branch), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_mem_2_reg(id_mem_2_reg), .id_reg_write(id_reg_write),
        .id_jump(id_jump), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .flush(flush),
        .stall(stall), .ex_valid(ex_valid), .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src),
        .ex_rt(ex_rt), .ex_write_reg(ex_write_reg), .mem_valid(mem_valid),
        .mem_branch(mem_branch), .mem_jump(mem_jump), .mem_mem_read(mem_mem_read),
        .mem_mem_write(mem_mem_write), .mem_write_reg(mem_write_reg), .wb_valid(wb_valid),
        .wb_reg_write(wb_reg_write), .wb_mem_2_reg(wb_mem_2_reg), .wb_write_reg(wb_write_reg),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    ctrl_pipeline #(.REG_ADDR_W(5), .CNT_W(2)) dut2 (
        .clk(clk), .arst_n(arst_n),
        .id_valid(id_valid), .id_alu_op(id_alu_op), .id_reg_dst(id_reg_dst),
        .id_alu_src(id_alu_src), .id_branch(id_branch), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_mem_2_reg(id_mem_2_reg), .id_reg_write(id_reg_write),
        .id_jump(id_jump), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .flush(flush),
        .stall(d2_stall), .ex_valid(d2_ex_valid), .ex_alu_op(d2_ex_alu_op),
        .ex_alu_src(d2_ex_alu_src), .ex_rt(d2_ex_rt), .ex_write_reg(d2_ex_write_reg),
        .mem_valid(d2_mem_valid), .mem_branch(d2_mem_branch), .mem_jump(d2_mem_jump),
        .mem_mem_read(d2_mem_mem_read), .mem_mem_write(d2_mem_mem_write),
        .mem_write_reg(d2_mem_write_reg), .wb_valid(d2_wb_valid),
        .wb_reg_write(d2_wb_reg_write), .wb_mem_2_reg(d2_wb_mem_2_reg),
        .wb_write_reg(d2_wb_write_reg), .stall_cnt(d2_stall_cnt), .flush_cnt(d2_flush_cnt)
    );

    // Every non-counter output of each instance, so that reset can be checked in one compare
    logic [32:0] pipe_out, d2_pipe_out;
    assign pipe_out = {stall, ex_valid, ex_alu_op, ex_alu_src, ex_rt, ex_write_reg,
                       mem_valid, mem_branch, mem_jump, mem_mem_read, mem_mem_write, mem_write_reg,
                       wb_valid, wb_reg_write, wb_mem_2_reg, wb_write_reg};
    assign d2_pipe_out = {d2_stall, d2_ex_valid, d2_ex_alu_op, d2_ex_alu_src, d2_ex_rt,
                          d2_ex_write_reg, d2_mem_valid, d2_mem_branch, d2_mem_jump,
                          d2_mem_mem_read, d2_mem_mem_write, d2_mem_write_reg, d2_wb_valid,
                          d2_wb_reg_write, d2_wb_mem_2_reg, d2_wb_write_reg};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock, then settle 1 ns past the edge before anything is sampled or driven
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [1:0] op, input logic rdst, input logic asrc,
                          input logic br, input logic mrd, input logic mwr, input logic m2r,
                          input logic rwr, input logic jmp, input logic [4:0] rs,
                          input logic [4:0] rt, input logic [4:0] rd);
        id_valid = v;    id_alu_op = op;     id_reg_dst = rdst; id_alu_src = asrc;
        id_branch = br;  id_mem_read = mrd;  id_mem_write = mwr; id_mem_2_reg = m2r;
        id_reg_write = rwr; id_jump = jmp;   id_rs = rs; id_rt = rt; id_rd = rd;
        #1;
    endtask

    task automatic id_nop();
        set_id(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    endtask

    // The reset is applied and released between clock edges
    task automatic do_reset();
        flush = 1'b0;
        id_nop();
        arst_n = 1'b0;
        #2;
        arst_n = 1'b1;
    endtask

    initial begin
        flush = 1'b0;
        id_nop();

        // ---- 1: reset state, then asynchronous reset in the middle of a stream
        #2;
        chk("reset_pipe", 64'(pipe_out), 64'(0));
        chk("reset_cnt", 64'({stall_cnt, flush_cnt}), 64'(0));
        @(negedge clk);
        arst_n = 1'b1;
        step();
        set_id(1, 2'b10, 1, 0, 0, 0, 0, 0, 1, 0, 5'd1, 5'd2, 5'd3);   // add r3,r1,r2
        step();
        set_id(1, 2'b00, 0, 1, 0, 1, 0, 1, 1, 0, 5'd1, 5'd5, 5'd0);   // lw r5,0(r1)
        step();
        set_id(1, 2'b10, 1, 0, 0, 0, 0, 0, 1, 0, 5'd5, 5'd1, 5'd6);   // add r6,r5,r1 -> stall
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        chk("pre_rst_cnt", 64'({stall_cnt, flush_cnt}), {32'd0, 16'd1, 16'd1});
        chk("pre_rst_ex_valid", 64'(ex_valid), 64'(1));
        #2;
        arst_n = 1'b0;                  // mid-cycle, no edge involved
        #1;
        chk("midrst_pipe", 64'(pipe_out), 64'(0));
        chk("midrst_cnt", 64'({stall_cnt, flush_cnt}), 64'(0));
        step();                         // an edge with a valid ID must not load anything
        chk("rst_held_pipe", 64'(pipe_out), 64'(0));
        chk("rst_held_d2", 64'({d2_pipe_out, d2_stall_cnt, d2_flush_cnt}), 64'(0));
        arst_n = 1'b1;

        // ---- 2: add r3,r1,r2 through the pipe
        do_reset();
        set_id(1, 2'b10, 1, 0, 0, 0, 0, 0, 1, 0, 5'd1, 5'd2, 5'd3);
        step();
        chk("add_ex", 64'({ex_valid, ex_alu_op, ex_alu_src, ex_rt, ex_write_reg}),
            64'({1'b1, 2'b10, 1'b0, 5'd2, 5'd3}));
        id_nop();
        step();
        chk("add_mem", 64'({ex_valid, mem_valid, mem_write_reg, mem_mem_read, mem_mem_write}),
            64'({1'b0, 1'b1, 5'd3, 1'b0, 1'b0}));
        step();
        chk("add_wb", 64'({wb_valid, wb_reg_write, wb_mem_2_reg, wb_write_reg}),
            64'({1'b1, 1'b1, 1'b0, 5'd3}));

        // ---- 3: load-use stall
        do_reset();
        set_id(1, 2'b00, 0, 1, 0, 1, 0, 1, 1, 0, 5'd1, 5'd5, 5'd0);   // lw r5,0(r1)
        step();
        chk("lw_ex_wreg", 64'(ex_write_reg), 64'(5));
        set_id(1, 2'b10, 1, 0, 0, 0, 0, 0, 1, 0, 5'd5, 5'd1, 5'd6);   // add r6,r5,r1
        chk("lu_stall", 64'(stall), 64'(1));
        step();
        chk("lu_bubble", 64'({ex_valid, ex_write_reg, mem_valid, mem_mem_read, mem_write_reg}),
            64'({1'b0, 5'd0, 1'b1, 1'b1, 5'd5}));
        chk("lu_stall_cnt", 64'(stall_cnt), 64'(1));
        chk("lu_stall_clear", 64'(stall), 64'(0));
        step();                                                         // ID is held by upstream
        chk("lu_add_ex", 64'({ex_valid, ex_write_reg}), 64'({1'b1, 5'd6}));
        chk("lu_lw_wb", 64'({wb_valid, wb_reg_write, wb_mem_2_reg, wb_write_reg}),
            64'({1'b1, 1'b1, 1'b1, 5'd5}));
        chk("lu_stall_cnt_hold", 64'(stall_cnt), 64'(1));

        // ---- 4: flush with a simultaneous load-use hazard, then a back-to-back flush
        do_reset();
        set_id(1, 2'b01, 0, 0, 1, 0, 0, 0, 0, 0, 5'd1, 5'd2, 5'd0);   // beq r1,r2
        step();
        set_id(1, 2'b00, 0, 1, 0, 1, 0, 1, 1, 0, 5'd1, 5'd7, 5'd0);   // lw r7,0(r1)
        step();
        chk("br_in_mem", 64'({mem_valid, mem_branch}), 64'({1'b1, 1'b1}));
        set_id(1, 2'b10, 1, 0, 0, 0, 0, 0, 1, 0, 5'd7, 5'd1, 5'd8);   // add r8,r7,r1
        flush = 1'b1;
        #1;
        chk("fl_no_stall", 64'(stall), 64'(0));
        step();
        chk("fl_squash", 64'({ex_valid, mem_valid, wb_valid, wb_reg_write, wb_write_reg}),
            64'({1'b0, 1'b0, 1'b1, 1'b0, 5'd2}));
        chk("fl_cnts", 64'({stall_cnt, flush_cnt}), 64'({16'd0, 16'd1}));
        step();                                                         // second flush
        flush = 1'b0;
        chk("fl2", 64'({ex_valid, mem_valid, wb_valid, flush_cnt}),
            64'({1'b0, 1'b0, 1'b0, 16'd2}));

        // ---- 5: jump with garbage enables, invalid ID, and a write to r0
        do_reset();
        set_id(1, 2'b00, 0, 0, 1, 1, 1, 0, 1, 1, 5'd4, 5'd4, 5'd4);   // j, enables all ones
        step();
        set_id(1, 2'b00, 0, 1, 0, 0, 0, 0, 1, 0, 5'd1, 5'd0, 5'd0);   // addi r0,r1,imm
        chk("j_no_stall", 64'(stall), 64'(0));
        step();
        chk("j_mem", 64'({mem_valid, mem_jump, mem_branch, mem_mem_read, mem_mem_write}),
            64'({1'b1, 1'b1, 1'b0, 1'b0, 1'b0}));
        set_id(0, 2'b10, 1, 0, 0, 0, 0, 0, 1, 0, 5'd1, 5'd2, 5'd4);   // not valid, reg_write=1
        step();
        chk("j_wb", 64'({wb_valid, wb_reg_write}), 64'({1'b1, 1'b0}));
        id_nop();
        step();
        chk("r0_wb", 64'({wb_valid, wb_reg_write, wb_write_reg}), 64'({1'b1, 1'b0, 5'd0}));
        step();
        chk("inv_wb", 64'({wb_valid, wb_reg_write, wb_write_reg}), 64'({1'b0, 1'b0, 5'd4}));

        // ---- 6: five stall cycles, with dut2 saturating its 2-bit counter at 3
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_id(1, 2'b00, 0, 1, 0, 1, 0, 1, 1, 0, 5'd1, 5'd5, 5'd0); // lw r5,0(r1)
            step();
            set_id(1, 2'b00, 0, 1, 0, 1, 0, 1, 1, 0, 5'd5, 5'd9, 5'd0); // lw r9,0(r5)
            step();
            if (i == 2) chk("sat_d2_at3", 64'(d2_stall_cnt), 64'(3));
        end
        chk("sat_main_cnt", 64'(stall_cnt), 64'(5));
        chk("sat_d2_cnt", 64'(d2_stall_cnt), 64'(3));
        chk("sat_d2_flush", 64'(d2_flush_cnt), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Watchdog: the stimulus above is a few hundred ns
    initial begin
        #20000;
        tests_failed++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $fatal(1, "timeout");
    end

endmodule
